// File: rtl/cpu_control_unit_pkg.sv
// rtl/cpu_control_unit_pkg.sv - shared state, class and ALU op codes for the CPU control unit
//
// Purpose: single source of the encodings used by the control unit and its
// instruction decoder.
// Contents: state_t (FSM state codes, visible on the debug port), class_t
// (IR[11:9] instruction class), ALU op constants, flags_t (latched C/N/Z).
package cpu_control_unit_pkg;

  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EX_ALU  = 4'd3,
    ST_EX_LD   = 4'd4,
    ST_EX_ST   = 4'd5,
    ST_EX_JMP  = 4'd6,
    ST_HALT    = 4'd7,
    ST_ILLEGAL = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LD   = 3'd1,
    CLS_ST   = 3'd2,
    CLS_JMP  = 3'd3,
    CLS_BC   = 3'd4,
    CLS_BN   = 3'd5,
    CLS_BZ   = 3'd6,
    CLS_HALT = 3'd7
  } class_t;

  localparam logic [3:0] OP_HALT   = 4'h0;
  localparam logic [3:0] OP_PASS_R = 4'h1;
  localparam logic [3:0] OP_PASS_S = 4'h2;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/cpu_control_unit_decode.sv
// rtl/cpu_control_unit_decode.sv - combinational decode of IR and latched flags into the post-DECODE state
//
// Purpose: chooses the state that follows DECODE. Memory moves must route the
// RAM word through the ALU (PASS_S), jumps must route the register (PASS_R),
// and HALT must carry op 0; anything else lands in ILLEGAL.
// Ports:
//   ir          in   16  instruction register from the EU
//   flags       in   3   latched {C,N,Z} from the last ALU instruction
//   next_state  out  4   state to enter after DECODE
module cpu_control_unit_decode
  import cpu_control_unit_pkg::*;
(
  input  logic [15:0] ir,
  input  flags_t      flags,
  output state_t      next_state
);

  logic [3:0] op;
  class_t     cls;

  assign op  = ir[15:12];
  assign cls = class_t'(ir[11:9]);

  always_comb begin
    next_state = ST_ILLEGAL;
    case (cls)
      CLS_ALU:  next_state = ST_EX_ALU;
      CLS_LD:   next_state = (op == OP_PASS_S) ? ST_EX_LD  : ST_ILLEGAL;
      CLS_ST:   next_state = (op == OP_PASS_S) ? ST_EX_ST  : ST_ILLEGAL;
      CLS_JMP:  next_state = (op == OP_PASS_R) ? ST_EX_JMP : ST_ILLEGAL;
      // An untaken branch retires straight from DECODE back to FETCH.
      CLS_BC:   next_state = flags.c ? ST_EX_JMP : ST_FETCH;
      CLS_BN:   next_state = flags.n ? ST_EX_JMP : ST_FETCH;
      CLS_BZ:   next_state = flags.z ? ST_EX_JMP : ST_FETCH;
      CLS_HALT: next_state = (op == OP_HALT) ? ST_HALT : ST_ILLEGAL;
      default:  next_state = ST_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - Moore FSM sequencing fetch/decode/execute for the CPU execution unit
//
// Purpose: state register, latched ALU flags, retired-instruction counter and
// Moore decode of EU strobes. Outputs depend on the state register only.
// Ports:
//   clk, reset (async active-low)
//   ir[15:0], C, N, Z            from the EU
//   adr_sel, s_sel, pc_ld, pc_inc, reg_W_en, ir_ld, mw_en   EU / RAM strobes
//   halted, illegal, state[3:0], icount[ICNT_W-1:0]         status / debug
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ir,
  input  logic              C,
  input  logic              N,
  input  logic              Z,
  output logic              adr_sel,
  output logic              s_sel,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              reg_W_en,
  output logic              ir_ld,
  output logic              mw_en,
  output logic              halted,
  output logic              illegal,
  output logic [3:0]        state,
  output logic [ICNT_W-1:0] icount
);

  state_t state_q;
  state_t state_d;
  state_t dec_next;
  flags_t flags_q;
  logic   retire;

  cpu_control_unit_decode u_decode (
    .ir         (ir),
    .flags      (flags_q),
    .next_state (dec_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:   state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = dec_next;
      ST_EX_ALU,
      ST_EX_LD,
      ST_EX_ST,
      ST_EX_JMP:  state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      ST_ILLEGAL: state_d = ST_ILLEGAL;
      default:    state_d = ST_ILLEGAL;
    endcase
  end

  always_comb begin
    adr_sel  = 1'b0;
    s_sel    = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    reg_W_en = 1'b0;
    ir_ld    = 1'b0;
    mw_en    = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      ST_EX_ALU: reg_W_en = 1'b1;
      ST_EX_LD: begin
        adr_sel  = 1'b1;
        s_sel    = 1'b1;
        reg_W_en = 1'b1;
      end
      ST_EX_ST: begin
        adr_sel = 1'b1;
        mw_en   = 1'b1;
      end
      ST_EX_JMP: pc_ld  = 1'b1;
      ST_HALT:   halted = 1'b1;
      ST_ILLEGAL: begin
        halted  = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

  // Flags reflect the ALU result of the instruction just executed; branches
  // see the value from the most recent ALU instruction, not the live flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (state_q == ST_EX_ALU) begin
      flags_q <= '{c: C, n: N, z: Z};
    end
  end

  assign retire = (state_q == ST_EX_ALU) || (state_q == ST_EX_LD) ||
                  (state_q == ST_EX_ST)  || (state_q == ST_EX_JMP) ||
                  ((state_q == ST_DECODE) && (dec_next == ST_FETCH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icount <= '0;
    end else if (retire) begin
      icount <= icount + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - self-checking bench for cpu_control_unit with a per-cycle expectation queue
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        C = 1'b0;
  logic        N = 1'b0;
  logic        Z = 1'b0;
  logic        adr_sel, s_sel, pc_ld, pc_inc, reg_W_en, ir_ld, mw_en;
  logic        halted, illegal;
  logic [3:0]  state;
  logic [3:0]  icount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] st;
    logic [3:0] icnt;
  } exp_t;

  exp_t exp_q[$];

  cpu_control_unit #(.ICNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .ir       (ir),
    .C        (C),
    .N        (N),
    .Z        (Z),
    .adr_sel  (adr_sel),
    .s_sel    (s_sel),
    .pc_ld    (pc_ld),
    .pc_inc   (pc_inc),
    .reg_W_en (reg_W_en),
    .ir_ld    (ir_ld),
    .mw_en    (mw_en),
    .halted   (halted),
    .illegal  (illegal),
    .state    (state),
    .icount   (icount)
  );

  always #5 clk = ~clk;

  // {adr_sel,s_sel,pc_ld,pc_inc,reg_W_en,ir_ld,mw_en,halted,illegal}
  function automatic logic [8:0] exp_strobes(input logic [3:0] st);
    case (st)
      4'd1:    return 9'b000101000;
      4'd3:    return 9'b000010000;
      4'd4:    return 9'b110010000;
      4'd5:    return 9'b100000100;
      4'd6:    return 9'b001000000;
      4'd7:    return 9'b000000010;
      4'd8:    return 9'b000000011;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic logic [8:0] act_strobes();
    return {adr_sel, s_sel, pc_ld, pc_inc, reg_W_en, ir_ld, mw_en, halted, illegal};
  endfunction

  task automatic push(input logic [3:0] st, input logic [3:0] icnt);
    exp_t e;
    e.st = st;
    e.icnt = icnt;
    exp_q.push_back(e);
  endtask

  // Advance one edge per queued expectation and compare the DUT after it.
  task automatic run(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s cycle %0d: scoreboard empty", tag, i);
      end else begin
        e = exp_q.pop_front();
        if (state !== e.st) begin
          errors++;
          $display("FAIL %s state cycle %0d: got %0d want %0d", tag, i, state, e.st);
        end
        checks++;
        if (act_strobes() !== exp_strobes(e.st)) begin
          errors++;
          $display("FAIL %s strobes cycle %0d: got %b want %b", tag, i, act_strobes(), exp_strobes(e.st));
        end
        checks++;
        if (icount !== e.icnt) begin
          errors++;
          $display("FAIL %s icount cycle %0d: got %0d want %0d", tag, i, icount, e.icnt);
        end
      end
      checks++;
      if ((pc_ld && pc_inc) || (reg_W_en && mw_en)) begin
        errors++;
        $display("FAIL %s exclusive strobes cycle %0d: pc_ld=%b pc_inc=%b reg_W_en=%b mw_en=%b",
                 tag, i, pc_ld, pc_inc, reg_W_en, mw_en);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (state !== 4'd0 || act_strobes() !== 9'b0 || icount !== 4'd0) begin
      errors++;
      $display("FAIL %s: state=%0d strobes=%b icount=%0d want 0/0/0", tag, state, act_strobes(), icount);
    end
  endtask

  // Reset low 3 cycles, release on a falling edge, expect FETCH on the next edge.
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_held");
    @(negedge clk);
    reset = 1'b1;
    push(4'd1, 4'd0);
    run(1, "reset_exit");
  endtask

  task automatic test_alu();
    ir = 16'h40CA;
    Z = 1'b1;
    push(4'd2, 4'd0);
    push(4'd3, 4'd0);
    push(4'd1, 4'd1);
    run(3, "alu");
  endtask

  task automatic test_branch();
    // flags_q.Z=1 from the ALU instruction; live Z low shows the latched copy is used.
    ir = 16'h1C08;
    Z = 1'b0;
    push(4'd2, 4'd1);
    push(4'd6, 4'd1);
    push(4'd1, 4'd2);
    run(3, "bz_taken");
    ir = 16'h40CA;
    Z = 1'b0;
    push(4'd2, 4'd2);
    push(4'd3, 4'd2);
    push(4'd1, 4'd3);
    run(3, "alu_clear_z");
    ir = 16'h1C08;
    Z = 1'b1;
    push(4'd2, 4'd3);
    push(4'd1, 4'd4);
    run(2, "bz_untaken");
  endtask

  task automatic test_ld_st();
    ir = 16'h22E8;
    push(4'd2, 4'd4);
    push(4'd4, 4'd4);
    push(4'd1, 4'd5);
    run(3, "ld");
    ir = 16'h242E;
    push(4'd2, 4'd5);
    push(4'd5, 4'd5);
    push(4'd1, 4'd6);
    run(3, "st");
  endtask

  task automatic test_reset_mid_store();
    ir = 16'h242E;
    push(4'd2, 4'd6);
    push(4'd5, 4'd6);
    run(2, "st_pre_reset");
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mw_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_store mw_en: got %b want 0", mw_en);
    end
    check_idle("mid_store_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    push(4'd1, 4'd0);
    run(1, "mid_store_exit");
  endtask

  task automatic test_back_to_back_wrap();
    logic [3:0] cnt = 4'd0;
    ir = 16'h40CA;
    for (int i = 0; i < 16; i++) begin
      push(4'd2, cnt);
      push(4'd3, cnt);
      cnt = cnt + 4'd1;
      push(4'd1, cnt);
      run(3, "wrap");
    end
    checks++;
    if (icount !== 4'd0) begin
      errors++;
      $display("FAIL wrap final icount: got %0d want 0", icount);
    end
  endtask

  task automatic test_halt();
    ir = 16'h0E00;
    push(4'd2, 4'd0);
    for (int i = 0; i < 11; i++) push(4'd7, 4'd0);
    run(12, "halt");
  endtask

  task automatic test_illegal(input logic [15:0] word);
    test_reset();
    ir = word;
    push(4'd2, 4'd0);
    for (int i = 0; i < 4; i++) push(4'd8, 4'd0);
    run(5, "illegal");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_ld_st();
    test_reset_mid_store();
    test_back_to_back_wrap();
    test_halt();
    test_illegal(16'h5E00);
    test_illegal(16'h32E8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
